// File: rtl/instr_sequencer.sv
// Program sequencer for simple_cpu: holds a loadable program store and issues
// one instruction at a time, each held for ISSUE_CYCLES cycles, with jump/halt.
module instr_sequencer #(
   parameter int                     INSTR_WIDTH  = 20,
   parameter int                     PC_BITS      = 5,
   parameter int                     ISSUE_CYCLES = 3,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = '0,
   parameter logic [3:0]             HALT_OP      = 4'hF,
   parameter logic [3:0]             JMP_OP       = 4'hE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   prog_wen,
   input  logic [PC_BITS-1:0]     prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   input  logic                   start,
   input  logic                   abort,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [PC_BITS-1:0]     pc_out,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             issued_cnt
);

   localparam int HOLD_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

   state_t                 state;
   logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];
   logic [INSTR_WIDTH-1:0] cur;
   logic [3:0]             op;
   logic [HOLD_W-1:0]      hold;
   logic [PC_BITS-1:0]     pc;

   assign cur    = mem[pc];
   assign op     = cur[INSTR_WIDTH-1 -: 4];
   assign pc_out = pc;
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);

   // Store is deliberately outside the reset domain so a program survives rst.
   always_ff @(posedge clk) begin
      if (state == IDLE && prog_wen)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         instr_out  <= NOP_INSTR;
         issued_cnt <= '0;
         hold       <= '0;
      end else if (abort && state != IDLE) begin
         state     <= IDLE;
         instr_out <= NOP_INSTR;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pc         <= '0;
                  issued_cnt <= '0;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (op == HALT_OP) begin
                  state <= DONE;
               end else if (op == JMP_OP) begin
                  pc <= cur[PC_BITS-1:0];
               end else begin
                  instr_out <= cur;
                  hold      <= HOLD_W'(ISSUE_CYCLES - 1);
                  if (issued_cnt != 8'hFF)
                     issued_cnt <= issued_cnt + 8'd1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (hold == '0) begin
                  instr_out <= NOP_INSTR;
                  pc        <= pc + 1'b1;
                  state     <= FETCH;
               end else begin
                  hold <= hold - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: walks the program in a behavioural model to build
// the expected per-cycle trace, then compares every cycle of the DUT against it.
module tb_instr_sequencer;

   localparam int          IC    = 3;
   localparam logic [19:0] NOP   = 20'h00000;
   localparam logic [19:0] HALTW = 20'hF0000;

   typedef struct {
      logic [19:0] instr;
      logic        busy;
      logic        done;
      logic [4:0]  pc;
      logic [7:0]  cnt;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_wen = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [19:0] prog_data = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [19:0] instr_out;
   logic [4:0]  pc_out;
   logic        busy;
   logic        done;
   logic [7:0]  issued_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [19:0] mm [32];
   ent_t        tq [$];
   bit          halted;

   instr_sequencer #(
      .INSTR_WIDTH (20),
      .PC_BITS     (5),
      .ISSUE_CYCLES(IC),
      .NOP_INSTR   (NOP),
      .HALT_OP     (4'hF),
      .JMP_OP      (4'hE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .prog_wen  (prog_wen),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .start     (start),
      .abort     (abort),
      .instr_out (instr_out),
      .pc_out    (pc_out),
      .busy      (busy),
      .done      (done),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pk(logic [19:0] i, logic b, logic d, logic [4:0] p, logic [7:0] c);
      return {29'd0, i, b, d, p, c};
   endfunction

   function automatic logic [63:0] dut_pk();
      return pk(instr_out, busy, done, pc_out, issued_cnt);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [4:0] a, input logic [19:0] d);
      @(negedge clk);
      prog_wen  = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(negedge clk);
      prog_wen = 1'b0;
      mm[a] = d;
   endtask

   // One entry per cycle after the start edge: a fetch cycle shows NOP, a normal
   // word then shows IC cycles of itself, a halt adds a done cycle then idle.
   task automatic build(input int limit);
      logic [4:0]  pc = '0;
      int          cnt = 0;
      logic [19:0] w;
      tq.delete();
      halted = 1'b0;
      while (tq.size() < limit && !halted) begin
         tq.push_back(ent_t'{NOP, 1'b1, 1'b0, pc, 8'(cnt)});
         w = mm[pc];
         case (w[19:16])
            4'hF: begin
               tq.push_back(ent_t'{NOP, 1'b1, 1'b1, pc, 8'(cnt)});
               tq.push_back(ent_t'{NOP, 1'b0, 1'b0, pc, 8'(cnt)});
               halted = 1'b1;
            end
            4'hE: pc = w[4:0];
            default: begin
               cnt = (cnt < 255) ? cnt + 1 : 255;
               repeat (IC) tq.push_back(ent_t'{w, 1'b1, 1'b0, pc, 8'(cnt)});
               pc = pc + 5'd1;
            end
         endcase
      end
   endtask

   // kind 0: run to halt; 1: abort after cut cycles; 2: rst after cut cycles.
   task automatic run(input string nm, input int kind_in, input int cut_in, input int poke,
                      input bit wr0, input logic [19:0] wd, input int limit);
      int   kind = kind_in;
      int   cut  = cut_in;
      int   n;
      ent_t e;
      if (wr0) mm[0] = wd;
      build(limit);
      if (kind == 0 && !halted) begin
         kind = 1;
         cut  = tq.size();
      end
      if (kind == 0) begin
         n = tq.size();
      end else begin
         if (cut > tq.size()) cut = tq.size();
         if (cut < 1) cut = 1;
         while (cut > 1 && !tq[cut-1].busy) cut--;
         n = cut;
      end
      @(negedge clk);
      start = 1'b1;
      if (wr0) begin
         prog_wen  = 1'b1;
         prog_addr = 5'd0;
         prog_data = wd;
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      prog_wen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
            start    = 1'b0;
            prog_wen = 1'b0;
         end
         e = tq[i];
         check($sformatf("%s_c%0d", nm, i), dut_pk(), pk(e.instr, e.busy, e.done, e.pc, e.cnt));
         if (i == poke && i < n - 1 && e.busy) begin
            start     = 1'b1;
            prog_wen  = 1'b1;
            prog_addr = 5'd2;
            prog_data = ~mm[2];
         end
      end
      e = tq[n-1];
      if (kind == 1) begin
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
         check({nm, "_abort"}, dut_pk(), pk(NOP, 1'b0, 1'b0, e.pc, e.cnt));
      end else if (kind == 2) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         check({nm, "_rst"}, dut_pk(), pk(NOP, 1'b0, 1'b0, 5'd0, 8'd0));
      end
   endtask

   initial begin
      logic [19:0] w;
      int          r;
      repeat (2) @(posedge clk);
      #1;
      check("reset", dut_pk(), pk(NOP, 1'b0, 1'b0, 5'd0, 8'd0));
      rst = 1'b0;
      for (int a = 0; a < 32; a++) load(5'(a), HALTW);

      load(5'd0, 20'h12345);
      load(5'd1, 20'h20011);
      load(5'd2, HALTW);
      run("t1", 0, 0, -1, 1'b0, NOP, 200);
      check("t1_cnt", 64'(issued_cnt), 64'd2);
      check("t1_pc", 64'(pc_out), 64'd2);

      run("t4", 0, 0, 3, 1'b0, NOP, 200);
      run("t4b", 0, 0, -1, 1'b0, NOP, 200);
      check("t4b_cnt", 64'(issued_cnt), 64'd2);

      run("t6", 2, 3, -1, 1'b0, NOP, 200);
      run("t6b", 0, 0, -1, 1'b0, NOP, 200);
      check("t6b_cnt", 64'(issued_cnt), 64'd2);

      load(5'd0, 20'hE0004);
      load(5'd4, 20'h300AA);
      load(5'd5, HALTW);
      run("t2", 0, 0, -1, 1'b0, NOP, 200);
      check("t2_cnt", 64'(issued_cnt), 64'd1);
      check("t2_pc", 64'(pc_out), 64'd5);

      load(5'd0, 20'hE001F);
      load(5'd31, 20'h10001);
      run("t3", 1, 15, -1, 1'b0, NOP, 200);
      check("t3_cnt", 64'(issued_cnt), 64'd3);
      check("t3_out", 64'({instr_out, busy, done}), 64'd0);

      load(5'd0, 20'h50001);
      load(5'd1, 20'hE0000);
      run("t5", 1, 5000, -1, 1'b0, NOP, 1600);
      check("t5_cnt", 64'(issued_cnt), 64'd255);

      load(5'd0, HALTW);
      load(5'd1, HALTW);
      run("ws", 0, 0, -1, 1'b1, 20'h70042, 200);
      check("ws_cnt", 64'(issued_cnt), 64'd1);

      for (int k = 0; k < 12; k++) begin
         for (int a = 0; a < 32; a++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      w = HALTW;
            else if (r == 1) w = {4'hE, 11'd0, 5'($urandom_range(0, 31))};
            else             w = {4'($urandom_range(0, 13)), 16'($urandom)};
            load(5'(a), w);
         end
         run($sformatf("rnd%0d", k), $urandom_range(0, 2), $urandom_range(1, 60),
             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1, 1'b0, NOP, 400);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
